// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read-side logic: default entry width,
// counter-width helper and a lane-index type for packers built on the FIFO.
package afifo_pkg;

    localparam int AFIFO_DATA_W   = 8;
    localparam int AFIFO_MAX_PACK = 16;

    typedef logic [$clog2(AFIFO_MAX_PACK)-1:0] lane_idx_t;

    // Width needed to count 0..pack inclusive.
    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/afifo_rd_packer.sv
// Read-side consumer of the async FIFO: packs PACK consecutive entries into one
// valid/ready output word. `define PACKER_FLUSH_EN adds flush / out_bytes (partial words).
//
// Handshake: a word transfers on any r_clk edge where out_valid && out_ready; while
// out_valid && !out_ready, out_data and out_valid are held unchanged.
module afifo_rd_packer
    import afifo_pkg::*;
#(
    parameter  int DATA_W = AFIFO_DATA_W,
    parameter  int PACK   = 4,
    localparam int OUT_W  = DATA_W * PACK,
    localparam int CNT_W  = cnt_w(PACK)
) (
    input  logic              r_clk,
    input  logic              clr,
    input  logic              empty,
    input  logic [DATA_W-1:0] r_data,
    output logic              read_en,
    input  logic              out_ready,
`ifdef PACKER_FLUSH_EN
    input  logic              flush,
    output logic [CNT_W-1:0]  out_bytes,
`endif
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid
);

    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic [OUT_W-1:0] asm_q;
    logic             out_free;
    logic [CNT_W:0]   inflight;
    logic             bypass_done;
    logic             held_done;
    logic             partial_go;
    logic             blocked;

    assign out_free    = !out_valid || out_ready;
    assign inflight    = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
    assign bypass_done = pend && (cnt == CNT_W'(PACK - 1)) && out_free;
    assign held_done   = (cnt == CNT_W'(PACK)) && out_free;

`ifdef PACKER_FLUSH_EN
    logic flush_req;
    logic flush_go;

    // Flush waits for the last in-flight byte to land before emitting.
    assign flush_go   = flush_req && !pend && out_free;
    assign partial_go = flush_go && (cnt != '0) && (cnt != CNT_W'(PACK));
    assign blocked    = flush_req;

    always_ff @(posedge r_clk or posedge clr) begin
        if (clr) begin
            flush_req <= 1'b0;
        end else begin
            flush_req <= flush || (flush_req && !flush_go);
        end
    end
`else
    assign partial_go = 1'b0;
    assign blocked    = 1'b0;
`endif

    // A read may target the last free lane only if that word can leave on arrival.
    assign read_en = !clr && !empty && !blocked &&
                     ((inflight < (CNT_W+1)'(PACK)) ||
                      ((inflight == (CNT_W+1)'(PACK)) && out_free));

    always_ff @(posedge r_clk or posedge clr) begin
        if (clr) begin
            cnt       <= '0;
            pend      <= 1'b0;
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef PACKER_FLUSH_EN
            out_bytes <= '0;
`endif
        end else begin
            pend <= read_en;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bypass_done) begin
                out_data  <= {r_data, asm_q[OUT_W-DATA_W-1:0]};
                out_valid <= 1'b1;
                cnt       <= '0;
                asm_q     <= '0;
`ifdef PACKER_FLUSH_EN
                out_bytes <= CNT_W'(PACK);
`endif
            end else if (held_done || partial_go) begin
                out_data  <= asm_q;
                out_valid <= 1'b1;
                cnt       <= '0;
                asm_q     <= '0;
`ifdef PACKER_FLUSH_EN
                out_bytes <= cnt;
`endif
            end else if (pend) begin
                for (int k = 0; k < PACK; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        asm_q[k*DATA_W +: DATA_W] <= r_data;
                    end
                end
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Scoreboard bench for afifo_rd_packer: a queue-based FIFO model feeds bytes, a byte-stream
// reference model predicts packed words, and a monitor checks every accepted word.
`timescale 1ns/1ps
module tb_afifo_rd_packer;
    import afifo_pkg::*;

    localparam int DATA_W = AFIFO_DATA_W;
    localparam int PACK   = 4;
    localparam int OUT_W  = DATA_W * PACK;
    localparam int CNT_W  = cnt_w(PACK);

    logic              r_clk = 1'b0;
    logic              clr = 1'b0;
    logic              empty = 1'b1;
    logic [DATA_W-1:0] r_data = '0;
    logic              read_en;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
`ifdef PACKER_FLUSH_EN
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  out_bytes;
    logic [CNT_W-1:0]  exp_bytes_q[$];
`endif

    int                checks = 0;
    int                errors = 0;
    logic [OUT_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] part_q[$];
    logic              gap = 1'b0;

    afifo_rd_packer #(.DATA_W(DATA_W), .PACK(PACK)) dut (
        .r_clk     (r_clk),
        .clr       (clr),
        .empty     (empty),
        .r_data    (r_data),
        .read_en   (read_en),
        .out_ready (out_ready),
`ifdef PACKER_FLUSH_EN
        .flush     (flush),
        .out_bytes (out_bytes),
`endif
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    // ---------------- clock ----------------
    always #5 r_clk = ~r_clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model: data appears the cycle after a strobe ----------------
    initial begin : fifo_model
        logic do_rd;
        forever begin
            @(negedge r_clk);
            do_rd = read_en && !empty;
            @(posedge r_clk);
            #1;
            if (do_rd) begin
                if (fifo_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_underrun act=read exp=no_read");
                end else begin
                    r_data = fifo_q.pop_front();
                end
            end
            empty = gap || (fifo_q.size() == 0);
        end
    end

    // ---------------- reference model: bytes in FIFO order, lane 0 first ----------------
    task automatic push_byte(input logic [DATA_W-1:0] b);
        logic [OUT_W-1:0] w;
        fifo_q.push_back(b);
        part_q.push_back(b);
        if (part_q.size() == PACK) begin
            w = '0;
            for (int k = 0; k < PACK; k++) w[k*DATA_W +: DATA_W] = part_q[k];
            exp_q.push_back(w);
`ifdef PACKER_FLUSH_EN
            exp_bytes_q.push_back(CNT_W'(PACK));
`endif
            part_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic             stalled;
        logic [OUT_W-1:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge r_clk);
            if (clr || empty) check("read_en_blocked", read_en, 1'b0);
            if (stalled) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word act=%0h exp=none", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
`ifdef PACKER_FLUSH_EN
                    check("out_bytes", out_bytes, exp_bytes_q.pop_front());
`endif
                end
            end
            stalled = out_valid && !out_ready && !clr;
            held    = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || out_valid) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_drain"}, (n < budget), 1'b1);
        tick(3);
    endtask

    initial begin : main
        int first_re, first_ov, acc0, acc1, run, max_run, n;

        // T1 reset
        #2;
        clr = 1'b1;
        out_ready = 1'b1;
        tick(1);
        for (int b = 0; b < PACK; b++) push_byte(8'hA0 + 8'(b));
        tick(2);
        @(negedge r_clk);
        check("t1_read_en_rst", read_en, 1'b0);
        check("t1_valid_rst", out_valid, 1'b0);
        check("t1_data_rst", out_data, '0);
        @(posedge r_clk);
        #1;
        clr = 1'b0;
        @(negedge r_clk);
        check("t1_read_en_release", read_en, 1'b1);
        wait_drain("t1", 50);

        // T2 streaming
        first_re = -1; first_ov = -1; acc0 = -1; acc1 = -1; run = 0; max_run = 0;
        for (int b = 0; b < 8; b++) push_byte(8'(b));
        for (int i = 0; i < 40; i++) begin
            @(negedge r_clk);
            if (read_en) begin
                run++;
                if (first_re < 0) first_re = i;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (out_valid && first_ov < 0) first_ov = i;
            if (out_valid && out_ready) begin
                if (acc0 < 0) acc0 = i;
                else if (acc1 < 0) acc1 = i;
            end
        end
        check("t2_latency", 64'(first_ov - first_re), 64'(PACK + 1));
        check("t2_spacing", 64'(acc1 - acc0), 64'(PACK));
        check("t2_read_run", 64'(max_run), 64'd8);
        tick(1);
        wait_drain("t2", 50);

        // T3 backpressure
        out_ready = 1'b0;
        for (int b = 0; b < 12; b++) push_byte(8'(b));
        tick(20);
        @(negedge r_clk);
        check("t3_valid_held", out_valid, 1'b1);
        check("t3_first_word", out_data, 32'h03020100);
        check("t3_read_en_stalled", read_en, 1'b0);
        check("t3_fifo_left", 64'(fifo_q.size()), 64'd4);
        @(posedge r_clk);
        #1;
        out_ready = 1'b1;
        wait_drain("t3", 60);

        // T4 underflow gap
        push_byte(8'h00);
        push_byte(8'h01);
        n = 0;
        while (fifo_q.size() != 0 && n < 20) begin
            tick(1);
            n++;
        end
        check("t4_first_bytes_read", (n < 20), 1'b1);
        gap = 1'b1;
        push_byte(8'h02);
        push_byte(8'h03);
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            check("t4_gap_no_word", out_valid, 1'b0);
        end
        @(posedge r_clk);
        #1;
        gap = 1'b0;
        wait_drain("t4", 50);

        // T5 reset mid-word
        push_byte(8'h20);
        push_byte(8'h21);
        tick(6);
        clr = 1'b1;
        part_q.delete();
        tick(1);
        clr = 1'b0;
        @(negedge r_clk);
        check("t5_valid_after_clr", out_valid, 1'b0);
        for (int b = 0; b < PACK; b++) push_byte(8'h10 + 8'(b));
        wait_drain("t5", 50);

`ifdef PACKER_FLUSH_EN
        // T6 flush of a partial word, then a flush with nothing buffered
        begin
            logic [OUT_W-1:0] w;
            push_byte(8'hAA);
            push_byte(8'hBB);
            push_byte(8'hCC);
            tick(8);
            w = '0;
            for (int k = 0; k < part_q.size(); k++) w[k*DATA_W +: DATA_W] = part_q[k];
            exp_q.push_back(w);
            exp_bytes_q.push_back(CNT_W'(part_q.size()));
            part_q.delete();
            flush = 1'b1;
            tick(1);
            flush = 1'b0;
            wait_drain("t6", 30);
            flush = 1'b1;
            tick(1);
            flush = 1'b0;
            tick(10);
        end
`endif

        // random traffic with random stalls and FIFO gaps
        for (int c = 0; c < 1500; c++) begin
            tick(1);
            out_ready = ($urandom_range(0, 3) != 0);
            gap       = ($urandom_range(0, 9) == 0);
            if (fifo_q.size() < 24 && $urandom_range(0, 2) == 0) begin
                for (int k = 0; k < PACK; k++) push_byte(8'($urandom_range(0, 255)));
            end
        end
        out_ready = 1'b1;
        gap = 1'b0;
        wait_drain("rand", 400);

        check("end_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
